// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-map interconnect.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int          LATW        = 4;
    localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_bus_fabric_if.sv
// Processor-side data port of the fabric: request, response and status.
interface mem_bus_fabric_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          busy;
    logic          err;

    modport master (output req, we, addr, wdata, input ack, rdata, busy, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, busy, err);
endinterface

// File: rtl/mem_bus_decode.sv
// Address page -> region decode. Takes addr[AW-1:RSHIFT] only; the low
// in-region bits are irrelevant here. Anything outside the NREG regions is
// unmapped (no wrap / aliasing of upper address bits).
module mem_bus_decode #(
    parameter int AW     = 32,
    parameter int NREG   = 4,
    parameter int RSHIFT = 14,
    localparam int IW    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic [AW-RSHIFT-1:0] page_i,
    output logic                 mapped_o,
    output logic [IW-1:0]        idx_o,
    output logic [NREG-1:0]      sel_o
);
    logic upper_zero;

    assign idx_o = page_i[IW-1:0];

    generate
        if (AW - RSHIFT > IW) begin : g_upper
            assign upper_zero = (page_i[AW-RSHIFT-1:IW] == '0);
        end else begin : g_noupper
            assign upper_zero = 1'b1;
        end
    endgenerate

    assign mapped_o = upper_zero && (int'(idx_o) < NREG);

    // One-hot select, all-zero when unmapped
    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NREG; i++)
            if (mapped_o && int'(idx_o) == i) sel_o[i] = 1'b1;
    end
endmodule

// File: rtl/mem_bus_fabric.sv
// Memory-map interconnect: processor data port -> NREG aligned slave regions
// with per-region wait states and registered read data.
// Optional MEM_BUS_ERR_EN: unmapped reads return ERR_PATTERN and pulse err.
module mem_bus_fabric
    import mem_bus_pkg::*;
#(
    parameter int                    AW         = 32,
    parameter int                    DW         = 32,
    parameter int                    NREG       = 4,
    parameter int                    RSHIFT     = 14,
    parameter logic [NREG*LATW-1:0]  REGION_LAT = {NREG{4'd0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bus_fabric_if.slave      bus,
    output logic [NREG-1:0]      sel,
    output logic                 rd,
    output logic                 wr,
    output logic [AW-1:0]        laddr,
    output logic [DW-1:0]        lwdata,
    input  logic [NREG*DW-1:0]   region_rdata
);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
`ifdef MEM_BUS_ERR_EN
    localparam logic [DW-1:0] ERR_VAL = DW'(ERR_PATTERN);
`else
    localparam logic [DW-1:0] ERR_VAL = '0;
`endif

    state_t            state_q, state_d;
    logic [LATW-1:0]   cnt_q, cnt_d, lat_ld;
    logic              we_q, mapped_q, first_q;
    logic [IW-1:0]     idx_q;
    logic [NREG-1:0]   sel_q;
    logic [AW-1:0]     laddr_q;
    logic [DW-1:0]     lwdata_q, rdata_q, rsel;

    logic              dec_mapped;
    logic [IW-1:0]     dec_idx;
    logic [NREG-1:0]   dec_sel;

    mem_bus_decode #(.AW(AW), .NREG(NREG), .RSHIFT(RSHIFT)) u_decode (
        .page_i   (bus.addr[AW-1:RSHIFT]),
        .mapped_o (dec_mapped),
        .idx_o    (dec_idx),
        .sel_o    (dec_sel)
    );

    // Wait-state count of the region being requested
    always_comb begin
        lat_ld = '0;
        for (int i = 0; i < NREG; i++)
            if (int'(dec_idx) == i) lat_ld = REGION_LAT[i*LATW +: LATW];
    end

    // Read data of the latched region, error value when unmapped
    always_comb begin
        rsel = ERR_VAL;
        for (int i = 0; i < NREG; i++)
            if (mapped_q && int'(idx_q) == i) rsel = region_rdata[i*DW +: DW];
    end

    // Next state and wait counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.req) begin
                state_d = ACCESS;
                cnt_d   = lat_ld;
            end
            ACCESS: begin
                if (cnt_q != '0) cnt_d   = cnt_q - 1'b1;
                else             state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request latches and read-data capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            mapped_q <= 1'b0;
            first_q  <= 1'b0;
            idx_q    <= '0;
            sel_q    <= '0;
            laddr_q  <= '0;
            lwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            if (state_q == IDLE && bus.req) begin
                we_q     <= bus.we;
                mapped_q <= dec_mapped;
                idx_q    <= dec_idx;
                sel_q    <= dec_sel;
                first_q  <= 1'b1;
                laddr_q  <= AW'(bus.addr[RSHIFT-1:0]);
                if (bus.we) lwdata_q <= bus.wdata;
            end
            if (state_q == ACCESS) begin
                first_q <= 1'b0;
                if (cnt_q == '0 && !we_q) rdata_q <= rsel;
            end
        end
    end

    // Strobes decode straight from state so reset drops them immediately
    assign sel      = (state_q == ACCESS) ? sel_q : '0;
    assign rd       = (state_q == ACCESS) && !we_q;
    assign wr       = (state_q == ACCESS) && we_q && first_q && mapped_q;
    assign laddr    = laddr_q;
    assign lwdata   = lwdata_q;

    assign bus.ack   = (state_q == RESP);
    assign bus.busy  = (state_q != IDLE);
    assign bus.rdata = rdata_q;
`ifdef MEM_BUS_ERR_EN
    assign bus.err   = (state_q == RESP) && !mapped_q;
`else
    assign bus.err   = 1'b0;
`endif
endmodule

// File: tb/tb_mem_bus_fabric.sv
// Self-checking bench for mem_bus_fabric (NREG=4, 16 KiB regions).
module tb_mem_bus_fabric;
    localparam int              AW     = 32;
    localparam int              DW     = 32;
    localparam int              NREG   = 4;
    localparam int              RSHIFT = 14;
    localparam logic [15:0]     LAT    = 16'h0530;  // r0=0 r1=3 r2=5 r3=0
    localparam logic [31:0]     MAP_TOP = 32'(NREG) << RSHIFT;
`ifdef MEM_BUS_ERR_EN
    localparam logic [31:0]     ERR_RD = 32'hDEAD_BEEF;
    localparam logic            ERR_FLAG = 1'b1;
`else
    localparam logic [31:0]     ERR_RD = 32'h0;
    localparam logic            ERR_FLAG = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bus_fabric_if #(.AW(AW), .DW(DW)) bus ();
    logic [NREG-1:0]    sel;
    logic               rd, wr;
    logic [AW-1:0]      laddr;
    logic [DW-1:0]      lwdata;
    logic [NREG*DW-1:0] region_rdata;
    logic [31:0]        reg_word [NREG];

    always_comb
        for (int i = 0; i < NREG; i++) region_rdata[i*DW +: DW] = reg_word[i];

    mem_bus_fabric #(.AW(AW), .DW(DW), .NREG(NREG), .RSHIFT(RSHIFT), .REGION_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sel(sel), .rd(rd), .wr(wr),
        .laddr(laddr), .lwdata(lwdata), .region_rdata(region_rdata)
    );

    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference model: region map from plain address arithmetic
    function automatic logic m_mapped(input logic [31:0] a);
        return a < MAP_TOP;
    endfunction
    function automatic int m_idx(input logic [31:0] a);
        return int'((a >> RSHIFT) % NREG);
    endfunction
    function automatic logic [3:0] m_lat(input logic [31:0] a);
        return 4'((LAT >> (4 * m_idx(a))) & 16'hF);
    endfunction
    function automatic logic [NREG-1:0] m_sel(input logic [31:0] a);
        return m_mapped(a) ? NREG'(1 << m_idx(a)) : '0;
    endfunction

    // One full access starting from IDLE; checks every cycle through the
    // IDLE cycle after ack. scramble perturbs master inputs while busy.
    task automatic run_access(input string tag, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] lat,
                              input logic [NREG-1:0] esel, input logic [31:0] erd,
                              input logic eerr, input bit scramble, input bit keep_req);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        for (int n = 0; n <= int'(lat); n++) begin
            if (n > 0) begin @(posedge clk); #1; end
            chk({tag, " busy"}, bus.busy, 1);
            chk({tag, " ack_early"}, bus.ack, 0);
            chk({tag, " sel"}, sel, esel);
            chk({tag, " rd"}, rd, !w);
            chk({tag, " wr"}, wr, (n == 0) && w && (esel != 0));
            if (n == 0) begin
                chk({tag, " laddr"}, laddr, a & 32'h3FFF);
                if (w) chk({tag, " lwdata"}, lwdata, d);
            end
            if (scramble) begin
                bus.addr = $urandom; bus.we = 1'($urandom); bus.wdata = $urandom;
            end
        end
        @(posedge clk); #1;
        if (!w) model_rdata = erd;
        chk({tag, " ack"}, bus.ack, 1);
        chk({tag, " err"}, bus.err, eerr);
        chk({tag, " rdata"}, bus.rdata, model_rdata);
        chk({tag, " strobes_resp"}, {sel, rd, wr}, 0);
        if (!keep_req) bus.req = 1'b0;
        @(posedge clk); #1;
        chk({tag, " idle"}, {bus.busy, bus.ack, bus.err}, 0);
    endtask

    typedef struct {
        string          nm;
        logic           we;
        logic [31:0]    addr;
        logic [31:0]    wdata;
        bit             scr;
        bit             keep;
        logic [NREG-1:0] esel;
        logic [3:0]     elat;
        logic [31:0]    erd;
        logic           eerr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        rst = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        reg_word[0] = 32'h1234_5678; reg_word[1] = 32'hCAFE_0001;
        reg_word[2] = 32'h2222_2222; reg_word[3] = 32'h3333_3333;

        tbl[0] = '{"rd_r0",      1'b0, 32'h0000_0010, 32'h0,         0, 0, 4'b0001, 4'd0, 32'h1234_5678, 1'b0};
        tbl[1] = '{"rd_r1_lat3", 1'b0, 32'h0000_4008, 32'h0,         0, 0, 4'b0010, 4'd3, 32'hCAFE_0001, 1'b0};
        tbl[2] = '{"wr_r2",      1'b1, 32'h0000_8004, 32'hA5A5_A5A5, 0, 0, 4'b0100, 4'd5, 32'h0,         1'b0};
        tbl[3] = '{"rd_unmap",   1'b0, 32'h0001_0000, 32'h0,         0, 0, 4'b0000, 4'd0, ERR_RD,        ERR_FLAG};
        tbl[4] = '{"b2b_rd_r3",  1'b0, 32'h0000_C000, 32'h0,         1, 1, 4'b1000, 4'd0, 32'h3333_3333, 1'b0};
        tbl[5] = '{"b2b_wr_r0",  1'b1, 32'h0000_0100, 32'h5555_0000, 1, 1, 4'b0001, 4'd0, 32'h0,         1'b0};
        tbl[6] = '{"b2b_rd_r1",  1'b0, 32'h0000_4000, 32'h0,         1, 0, 4'b0010, 4'd3, 32'hCAFE_0001, 1'b0};
        tbl[7] = '{"wr_unmap",   1'b1, 32'hFFFF_0000, 32'h7777_7777, 0, 0, 4'b0000, 4'd0, 32'h0,         ERR_FLAG};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {bus.ack, bus.busy, bus.err, sel, rd, wr}, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_laddr", laddr, 0);
        chk("rst_lwdata", lwdata, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_access(tbl[i].nm, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].elat,
                       tbl[i].esel, tbl[i].erd, tbl[i].eerr, tbl[i].scr, tbl[i].keep);

        // Reset in the middle of a slow read: strobes drop at once, no ack
        begin
            int acks = 0;
            bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h0000_4008;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("mid_rd_active", {sel, rd}, {4'b0010, 1'b1});
            bus.req = 1'b0;
            #2 rst = 1'b0;
            #1;
            chk("mid_rst_ctrl", {bus.ack, bus.busy, bus.err, sel, rd, wr}, 0);
            chk("mid_rst_data", {bus.rdata, laddr}, 0);
            model_rdata = 32'h0;
            @(negedge clk) rst = 1'b1;
            repeat (8) begin
                @(posedge clk); #1;
                if (bus.ack || bus.busy) acks++;
            end
            chk("mid_rst_no_ack", acks, 0);
        end

        // Randomized accesses against the reference model
        for (int k = 0; k < 40; k++) begin
            logic        w;
            logic [31:0] a, d;
            for (int r = 0; r < NREG; r++) reg_word[r] = $urandom;
            w = 1'($urandom);
            a = $urandom_range(0, 1) ? (32'($urandom_range(0, 32'hFFFF)) & ~32'h3) : $urandom;
            d = $urandom;
            run_access($sformatf("rnd%0d", k), w, a, d, m_lat(a), m_sel(a),
                       m_mapped(a) ? reg_word[m_idx(a)] : ERR_RD,
                       !m_mapped(a) && ERR_FLAG, bit'($urandom_range(0, 1)),
                       (k < 39) ? bit'($urandom_range(0, 1)) : 1'b0);
        end
        bus.req = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
